// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the register status table controller.
package rst_ctrl_pkg;
    localparam int RST_ENTRIES = 32;
    localparam int TAG_W       = 6;
    localparam int RST_ENTRY_W = 7;
    localparam int BUSY_BIT    = 6;
    localparam int RST_ADDR_W  = 5;
    localparam int CLR_STEPS   = RST_ENTRIES / 2;

    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [RST_ENTRY_W-1:0] rst_entry_t;
    typedef logic [RST_ADDR_W-1:0]  rst_addr_t;

    typedef enum logic {CLEAR, RUN} state_t;

    // Tags run 1..n; 0 is reserved so cleared entries never match a live tag.
    function automatic tag_t next_tag_wrap(input tag_t t, input int unsigned n);
        return (t == tag_t'(n)) ? tag_t'(1) : t + tag_t'(1);
    endfunction
endpackage

// File: rtl/rst_tag_alloc.sv
// In-order producer tag allocator: circular head/tail/count over tags 1..NUM_TAGS.
module rst_tag_alloc
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_TAGS = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic alloc,
    input  logic free,
    output tag_t next_tag,
    output logic full,
    output logic empty
);
    tag_t             head;
    tag_t             tail;
    logic [TAG_W:0]   count;
    logic             free_ok;

    assign next_tag = head;
    assign full     = (count == (TAG_W+1)'(NUM_TAGS));
    assign empty    = (count == '0);
    assign free_ok  = free & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= tag_t'(1);
            tail  <= tag_t'(1);
            count <= '0;
        end else if (clear) begin
            head  <= tag_t'(1);
            tail  <= tag_t'(1);
            count <= '0;
        end else begin
            if (alloc)   head <= next_tag_wrap(head, NUM_TAGS);
            if (free_ok) tail <= next_tag_wrap(tail, NUM_TAGS);
            if (alloc && !free_ok)      count <= count + 1'b1;
            else if (!alloc && free_ok) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/rst_ctrl.sv
// Register status table controller: rename on dispatch, source status read,
// CDB clear via lookup, and a two-entries-per-cycle table clear walk.
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_TAGS = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       disp_valid,
    output logic       disp_ready,
    input  rst_addr_t  disp_rd,
    input  rst_addr_t  disp_rs,
    input  rst_addr_t  disp_rt,
    input  logic       disp_wr,
    output tag_t       disp_tag,
    output logic       disp_rs_busy,
    output logic       disp_rt_busy,
    output tag_t       disp_rs_tag,
    output tag_t       disp_rt_tag,
    input  logic       cdb_valid,
    input  tag_t       cdb_tag,
    input  logic       commit_valid,
    input  logic       flush,
    output logic       init_busy,
    output rst_addr_t  rport0_addr,
    output rst_addr_t  rport1_addr,
    input  rst_entry_t rport0_data,
    input  rst_entry_t rport1_data,
    output rst_addr_t  wport0_addr,
    output rst_addr_t  wport1_addr,
    output rst_entry_t wport0_data,
    output rst_entry_t wport1_data,
    output logic       wport0_wen,
    output logic       wport1_wen,
    output tag_t       lookup_tag,
    input  logic       lookup_found,
    input  rst_addr_t  lookup_addr
);
    state_t     state;
    logic [3:0] clr_idx;
    logic       run, full, empty, accept, disp_wen, cdb_wen, clr_wen;

    assign run        = (state == RUN);
    assign init_busy  = (state == CLEAR);
    assign disp_ready = run & ~full;
    assign accept     = disp_valid & disp_ready & ~flush;

    rst_tag_alloc #(.NUM_TAGS(NUM_TAGS)) u_alloc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush),
        .alloc    (accept),
        .free     (commit_valid & run & ~flush),
        .next_tag (disp_tag),
        .full     (full),
        .empty    (empty)
    );

    assign disp_wen = accept & disp_wr & (disp_rd != '0);
    // The new rename wins over a CDB clear of the same register.
    assign cdb_wen  = run & ~flush & cdb_valid & (cdb_tag != '0) & lookup_found
                    & ~(disp_wen & (lookup_addr == disp_rd));
    assign clr_wen  = ~run & reset_n & ~flush;

    always_comb begin
        wport0_addr = disp_rd;
        wport0_data = {1'b1, disp_tag};
        wport0_wen  = disp_wen;
        wport1_addr = lookup_addr;
        wport1_data = '0;
        wport1_wen  = cdb_wen;
        if (clr_wen) begin
            wport0_addr = {clr_idx, 1'b0};
            wport0_data = '0;
            wport0_wen  = 1'b1;
            wport1_addr = {clr_idx, 1'b1};
            wport1_wen  = 1'b1;
        end
    end

    assign lookup_tag  = cdb_tag;
    assign rport0_addr = disp_rs;
    assign rport1_addr = disp_rt;
    assign disp_rs_tag = rport0_data[TAG_W-1:0];
    assign disp_rt_tag = rport1_data[TAG_W-1:0];
    // Sources see the pre-dispatch table, with a same-cycle CDB bypass.
    assign disp_rs_busy = rport0_data[BUSY_BIT] & (disp_rs != '0)
                        & ~(cdb_valid & (cdb_tag == rport0_data[TAG_W-1:0]));
    assign disp_rt_busy = rport1_data[BUSY_BIT] & (disp_rt != '0)
                        & ~(cdb_valid & (cdb_tag == rport1_data[TAG_W-1:0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (flush) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == 4'(CLR_STEPS - 1)) state <= RUN;
        end
    end
endmodule
